// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit sitting beside the EX ALU.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle.
// Operands are converted to magnitudes on entry. The result sign is fixed
// while the final value is registered on the way into DONE. The unit holds
// the pipeline through stall_req while an op is in flight, then presents a
// single registered writeback.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            we_in,
    input  logic [4:0]      waddr_in,
    output logic            stall_req,
    output logic            busy,
    output logic            valid,
    output logic            we,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        op_reg;
    logic              we_op_reg;
    logic [4:0]        waddr_op_reg;
    logic              neg_reg;
    logic [XLEN-1:0]   a_reg;     // multiplicand magnitude
    logic [XLEN-1:0]   b_reg;     // divisor magnitude
    logic [XLEN-1:0]   hi_reg;    // product high half / partial remainder
    logic [XLEN-1:0]   lo_reg;    // multiplier shifting out / quotient shifting in
    logic              valid_reg;
    logic              we_reg;
    logic [4:0]        waddr_reg;
    logic [XLEN-1:0]   wdata_reg;

    // Entry decode: operand signedness, magnitudes and the single-cycle special cases
    logic            sgn1_in, sgn2_in, neg1_in, neg2_in, neg_in;
    logic [XLEN-1:0] abs1_in, abs2_in;
    logic            div_zero_in, ovf_in, special_in;
    logic [XLEN-1:0] special_res;

    always_comb begin
        sgn1_in     = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        sgn2_in     = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        neg1_in     = sgn1_in & data1[XLEN-1];
        neg2_in     = sgn2_in & data2[XLEN-1];
        abs1_in     = neg1_in ? -data1 : data1;
        abs2_in     = neg2_in ? -data2 : data2;
        // A remainder takes the dividend's sign; everything else takes the xor
        neg_in      = (op == 3'b110) ? neg1_in : (neg1_in ^ neg2_in);
        div_zero_in = op[2] && (data2 == '0);
        ovf_in      = ((op == 3'b100) || (op == 3'b110)) && (data1 == MIN_VAL) && (data2 == '1);
        special_in  = div_zero_in | ovf_in;
        if (div_zero_in)
            special_res = op[1] ? data1 : '1;
        else
            special_res = op[1] ? '0 : MIN_VAL;
    end

    // One iteration step for both algorithms, plus the sign-corrected final result
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [XLEN-1:0]   hi_nx, lo_nx;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(XLEN+1){1'b0}});
        div_sh  = {hi_reg, lo_reg[XLEN-1]};
        div_ge  = div_sh >= {1'b0, b_reg};
        // When div_ge holds the true difference is below b_reg, so XLEN bits suffice
        div_sub = div_sh[XLEN-1:0] - b_reg;
        if (op_reg[2]) begin
            hi_nx = div_ge ? div_sub : div_sh[XLEN-1:0];
            lo_nx = {lo_reg[XLEN-2:0], div_ge};
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
        prod_fix = neg_reg ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
        if (!op_reg[2])
            final_res = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (!op_reg[1])
            final_res = neg_reg ? -lo_nx : lo_nx;
        else
            final_res = neg_reg ? -hi_nx : hi_nx;
    end

    // Control FSM, datapath registers and registered writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            op_reg       <= '0;
            we_op_reg    <= 1'b0;
            waddr_op_reg <= '0;
            neg_reg      <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            valid_reg    <= 1'b0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
        end else if (rdy) begin
            if (flush) begin
                state_reg <= ST_IDLE;
                valid_reg <= 1'b0;
                we_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            op_reg       <= op;
                            we_op_reg    <= we_in;
                            waddr_op_reg <= waddr_in;
                            neg_reg      <= neg_in;
                            cnt_reg      <= '0;
                            a_reg        <= abs1_in;
                            b_reg        <= abs2_in;
                            hi_reg       <= '0;
                            lo_reg       <= op[2] ? abs1_in : abs2_in;
                            if (special_in) begin
                                state_reg <= ST_DONE;
                                valid_reg <= 1'b1;
                                we_reg    <= we_in;
                                waddr_reg <= waddr_in;
                                wdata_reg <= special_res;
                            end else begin
                                state_reg <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        hi_reg  <= hi_nx;
                        lo_reg  <= lo_nx;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_CNT) begin
                            state_reg <= ST_DONE;
                            valid_reg <= 1'b1;
                            we_reg    <= we_op_reg;
                            waddr_reg <= waddr_op_reg;
                            wdata_reg <= final_res;
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                        valid_reg <= 1'b0;
                        we_reg    <= 1'b0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        valid_reg <= 1'b0;
                        we_reg    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pipeline hold and status; a flush landing on the result cycle masks the writeback
    always_comb begin
        stall_req = ((state_reg == ST_IDLE) && start) || (state_reg == ST_CALC);
        busy      = (state_reg == ST_CALC) || (state_reg == ST_DONE);
        valid     = valid_reg & ~(rdy & flush);
        we        = we_reg & ~(rdy & flush);
        waddr     = waddr_reg;
        wdata     = wdata_reg;
    end

endmodule
